// File: rtl/bus_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bus_cycle_sequencer
// Purpose  : Registered T-state machine driving CPU bus pin strobes for
//            fetch, memory, I/O and interrupt-acknowledge cycles.
// Revision : 1.0 - initial release
// ============================================================================
module bus_cycle_sequencer #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int MEM_WS     = 0,
    parameter int IO_WS      = 1,
    parameter int INTA_WS    = 2,
    parameter int BUSRQ_SYNC = 2
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic [2:0]    cycle_type,
    input  logic [AW-1:0] addr_in,
    input  logic [AW-1:0] rfsh_addr,
    input  logic [DW-1:0] db_in,
    input  logic          mwait,
    input  logic          busrq,
    output logic          accept,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] addr_out,
    output logic          m1,
    output logic          mreq,
    output logic          iorq,
    output logic          rd,
    output logic          wr,
    output logic          rfsh,
    output logic          busack,
    output logic          pin_oe,
    output logic          db_oe
);

    localparam logic [2:0] c_fetch   = 3'd0;
    localparam logic [2:0] c_mread   = 3'd1;
    localparam logic [2:0] c_mwrite  = 3'd2;
    localparam logic [2:0] c_ioread  = 3'd3;
    localparam logic [2:0] c_iowrite = 3'd4;
    localparam logic [2:0] c_inta    = 3'd5;

    localparam int c_ws_max = (MEM_WS > IO_WS) ? ((MEM_WS > INTA_WS) ? MEM_WS : INTA_WS)
                                               : ((IO_WS > INTA_WS) ? IO_WS : INTA_WS);
    localparam int c_wcw    = (c_ws_max < 2) ? 1 : $clog2(c_ws_max + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_T1    = 3'd1,
        S_T2    = 3'd2,
        S_TW    = 3'd3,
        S_T3    = 3'd4,
        S_T4    = 3'd5,
        S_GRANT = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_ctype;
    logic [2:0]            w_ctype_nxt;
    logic [2:0]            w_type_in;
    logic [c_wcw-1:0]      r_wcnt;
    logic [c_wcw-1:0]      w_wcnt_nxt;
    logic [BUSRQ_SYNC-1:0] r_busrq_sync;
    logic                  w_busrq_s;
    logic                  w_final;
    logic                  w_cap_rdata;
    logic                  w_load_rfsh;
    logic                  w_m1, w_mreq, w_iorq, w_rd, w_wr, w_rfsh, w_db_oe, w_done;

    function automatic logic is_long(input logic [2:0] t);
        return (t == c_fetch) || (t == c_inta);
    endfunction

    function automatic logic [c_wcw-1:0] class_ws(input logic [2:0] t);
        case (t)
            c_ioread, c_iowrite: class_ws = c_wcw'(IO_WS);
            c_inta:              class_ws = c_wcw'(INTA_WS);
            default:             class_ws = c_wcw'(MEM_WS);
        endcase
    endfunction

    assign w_busrq_s = r_busrq_sync[BUSRQ_SYNC-1];
    assign w_type_in = (cycle_type > c_inta) ? c_mread : cycle_type;
    assign w_final   = (r_state == S_T4) || ((r_state == S_T3) && !is_long(r_ctype));
    // Bus grant has priority: a pending start simply waits out the grant.
    assign accept    = start && !w_busrq_s && ((r_state == S_IDLE) || w_final);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_busrq_sync <= '0;
        end else begin
            r_busrq_sync[0] <= busrq;
            for (int i = 1; i < BUSRQ_SYNC; i++) begin
                r_busrq_sync[i] <= r_busrq_sync[i-1];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctype_nxt = r_ctype;
        w_wcnt_nxt  = r_wcnt;
        w_cap_rdata = 1'b0;
        w_load_rfsh = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (accept) begin
                    w_state_nxt = S_T1;
                    w_ctype_nxt = w_type_in;
                end else if (w_busrq_s) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_T1: begin
                w_state_nxt = S_T2;
                w_wcnt_nxt  = class_ws(r_ctype);
            end
            S_T2, S_TW: begin
                // Automatic waits take precedence; mwait only counts once they expire.
                if (r_wcnt != '0) begin
                    w_state_nxt = S_TW;
                    w_wcnt_nxt  = r_wcnt - c_wcw'(1);
                end else if (mwait) begin
                    w_state_nxt = S_TW;
                end else begin
                    w_state_nxt = S_T3;
                    w_cap_rdata = is_long(r_ctype);
                    w_load_rfsh = is_long(r_ctype);
                end
            end
            S_T3: begin
                w_cap_rdata = (r_ctype == c_mread) || (r_ctype == c_ioread);
                if (is_long(r_ctype)) begin
                    w_state_nxt = S_T4;
                end
            end
            S_T4: begin
                w_state_nxt = r_state;
            end
            S_GRANT: begin
                if (!w_busrq_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_final) begin
            if (accept) begin
                w_state_nxt = S_T1;
                w_ctype_nxt = w_type_in;
            end else if (w_busrq_s) begin
                w_state_nxt = S_GRANT;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // Strobe decode from the next state so every pin is a clean flop output.
    always_comb begin
        logic t12w, t2w, t13, t2w3, t34;
        t12w    = (w_state_nxt == S_T1) || (w_state_nxt == S_T2) || (w_state_nxt == S_TW);
        t2w     = (w_state_nxt == S_T2) || (w_state_nxt == S_TW);
        t13     = t12w || (w_state_nxt == S_T3);
        t2w3    = t2w || (w_state_nxt == S_T3);
        t34     = (w_state_nxt == S_T3) || (w_state_nxt == S_T4);
        w_m1    = 1'b0;
        w_mreq  = 1'b0;
        w_iorq  = 1'b0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_rfsh  = 1'b0;
        w_db_oe = 1'b0;
        case (w_ctype_nxt)
            c_fetch: begin
                w_m1   = t12w;
                w_mreq = t12w || t34;
                w_rd   = t12w;
                w_rfsh = t34;
            end
            c_mwrite: begin
                w_mreq  = t13;
                w_wr    = t2w;
                w_db_oe = t13;
            end
            c_ioread: begin
                w_iorq = t2w3;
                w_rd   = t2w3;
            end
            c_iowrite: begin
                w_iorq  = t2w3;
                w_wr    = t2w3;
                w_db_oe = t13;
            end
            c_inta: begin
                w_m1   = t12w;
                w_iorq = (w_state_nxt == S_TW);
                w_mreq = t34;
                w_rfsh = t34;
            end
            default: begin
                w_mreq = t13;
                w_rd   = t13;
            end
        endcase
        w_done = (w_state_nxt == S_T4) || ((w_state_nxt == S_T3) && !is_long(w_ctype_nxt));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= S_IDLE;
            r_ctype  <= c_fetch;
            r_wcnt   <= '0;
            addr_out <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            m1       <= 1'b0;
            mreq     <= 1'b0;
            iorq     <= 1'b0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            rfsh     <= 1'b0;
            db_oe    <= 1'b0;
            busack   <= 1'b0;
            pin_oe   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ctype <= w_ctype_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (accept) begin
                addr_out <= addr_in;
            end else if (w_load_rfsh) begin
                addr_out <= rfsh_addr;
            end
            if (w_cap_rdata) begin
                rdata <= db_in;
            end
            done   <= w_done;
            m1     <= w_m1;
            mreq   <= w_mreq;
            iorq   <= w_iorq;
            rd     <= w_rd;
            wr     <= w_wr;
            rfsh   <= w_rfsh;
            db_oe  <= w_db_oe;
            busack <= (w_state_nxt == S_GRANT);
            pin_oe <= (w_state_nxt != S_GRANT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_cycle_sequencer
// Purpose  : Directed self-checking bench for bus_cycle_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_sequencer;

    logic        clk = 1'b0;
    logic        nreset, start, mwait, busrq;
    logic [2:0]  cycle_type;
    logic [15:0] addr_in, rfsh_addr, addr_out;
    logic [7:0]  db_in, rdata;
    logic        accept, done, m1, mreq, iorq, rd, wr, rfsh, busack, pin_oe, db_oe;

    int total = 0;
    int bad   = 0;

    int          len, n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh, n_dboe;
    logic [15:0] a_first, a_last;
    logic        acc_seen, timed_out;

    bus_cycle_sequencer #(
        .AW(16), .DW(8), .MEM_WS(0), .IO_WS(1), .INTA_WS(2), .BUSRQ_SYNC(2)
    ) dut (
        .clk(clk), .nreset(nreset), .start(start), .cycle_type(cycle_type),
        .addr_in(addr_in), .rfsh_addr(rfsh_addr), .db_in(db_in), .mwait(mwait),
        .busrq(busrq), .accept(accept), .done(done), .rdata(rdata),
        .addr_out(addr_out), .m1(m1), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr),
        .rfsh(rfsh), .busack(busack), .pin_oe(pin_oe), .db_oe(db_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one cycle from IDLE and tallies strobe-high clocks up to done.
    task automatic run_cycle(input logic [2:0] t, input logic [15:0] a, input int mw);
        start = 1'b1; cycle_type = t; addr_in = a;
        #1;
        acc_seen = accept;
        tick();
        start = 1'b0;
        len = 0; n_m1 = 0; n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0; n_rfsh = 0; n_dboe = 0;
        a_first = '0; a_last = '0; timed_out = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            len = i;
            n_m1 += int'(m1); n_mreq += int'(mreq); n_iorq += int'(iorq);
            n_rd += int'(rd); n_wr += int'(wr); n_rfsh += int'(rfsh); n_dboe += int'(db_oe);
            if (i == 1) a_first = addr_out;
            if (done) begin
                a_last = addr_out;
                timed_out = 1'b0;
                break;
            end
            mwait = (i >= 2) && (i < 2 + mw);
            tick();
        end
        mwait = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #12;
        total++; if ({pin_oe, busack, done, mreq, m1, rd, wr, iorq} !== 8'h00) begin bad++; $display("FAIL reset_strobes got=%b want=00000000", {pin_oe, busack, done, mreq, m1, rd, wr, iorq}); end
        total++; if ({addr_out, rdata} !== 24'h0) begin bad++; $display("FAIL reset_data got=%h want=000000", {addr_out, rdata}); end
        @(posedge clk); #1; nreset = 1'b1;
        tick();
        total++; if (pin_oe !== 1'b1) begin bad++; $display("FAIL reset_pin_oe got=%b want=1", pin_oe); end
        total++; if (busack !== 1'b0) begin bad++; $display("FAIL reset_busack got=%b want=0", busack); end
    endtask

    task automatic test_fetch();
        db_in = 8'hA5; rfsh_addr = 16'h007F;
        run_cycle(3'd0, 16'h1234, 0);
        total++; if (acc_seen !== 1'b1) begin bad++; $display("FAIL fetch_accept got=%b want=1", acc_seen); end
        total++; if (timed_out || len != 4) begin bad++; $display("FAIL fetch_len got=%0d want=4", len); end
        total++; if (n_m1 != 2 || n_rd != 2 || n_rfsh != 2 || n_mreq != 4) begin bad++; $display("FAIL fetch_strobes m1/rd/rfsh/mreq got=%0d/%0d/%0d/%0d want=2/2/2/4", n_m1, n_rd, n_rfsh, n_mreq); end
        total++; if (a_first !== 16'h1234 || a_last !== 16'h007F) begin bad++; $display("FAIL fetch_addr got=%h->%h want=1234->007f", a_first, a_last); end
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL fetch_rdata got=%h want=a5", rdata); end
    endtask

    task automatic test_mwrite_wait();
        db_in = 8'h11;
        run_cycle(3'd2, 16'h8000, 2);
        total++; if (timed_out || len != 5) begin bad++; $display("FAIL mwrite_len got=%0d want=5", len); end
        total++; if (n_wr != 3 || n_dboe != 5 || n_mreq != 5 || n_rd != 0) begin bad++; $display("FAIL mwrite_strobes wr/dboe/mreq/rd got=%0d/%0d/%0d/%0d want=3/5/5/0", n_wr, n_dboe, n_mreq, n_rd); end
        total++; if (a_first !== 16'h8000) begin bad++; $display("FAIL mwrite_addr got=%h want=8000", a_first); end
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL mwrite_rdata_hold got=%h want=a5", rdata); end
    endtask

    task automatic test_io();
        db_in = 8'h3C;
        run_cycle(3'd3, 16'h00F0, 0);
        total++; if (timed_out || len != 4) begin bad++; $display("FAIL ioread_len got=%0d want=4", len); end
        total++; if (n_iorq != 3 || n_rd != 3 || n_mreq != 0) begin bad++; $display("FAIL ioread_strobes iorq/rd/mreq got=%0d/%0d/%0d want=3/3/0", n_iorq, n_rd, n_mreq); end
        total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL ioread_rdata got=%h want=3c", rdata); end
        run_cycle(3'd3, 16'h00F1, 1);
        total++; if (timed_out || len != 4) begin bad++; $display("FAIL ioread_mwait_masked got=%0d want=4", len); end
        run_cycle(3'd4, 16'h00F2, 0);
        total++; if (timed_out || len != 4) begin bad++; $display("FAIL iowrite_len got=%0d want=4", len); end
        total++; if (n_iorq != 3 || n_wr != 3 || n_dboe != 4) begin bad++; $display("FAIL iowrite_strobes iorq/wr/dboe got=%0d/%0d/%0d want=3/3/4", n_iorq, n_wr, n_dboe); end
    endtask

    task automatic test_inta();
        db_in = 8'hFF; rfsh_addr = 16'h0055;
        run_cycle(3'd5, 16'h0000, 0);
        total++; if (timed_out || len != 6) begin bad++; $display("FAIL inta_len got=%0d want=6", len); end
        total++; if (n_iorq != 2 || n_m1 != 4 || n_rfsh != 2 || n_mreq != 2) begin bad++; $display("FAIL inta_strobes iorq/m1/rfsh/mreq got=%0d/%0d/%0d/%0d want=2/4/2/2", n_iorq, n_m1, n_rfsh, n_mreq); end
        total++; if (rdata !== 8'hFF || a_last !== 16'h0055) begin bad++; $display("FAIL inta_data got=%h/%h want=ff/0055", rdata, a_last); end
    endtask

    task automatic test_type_alias();
        run_cycle(3'd7, 16'h2222, 0);
        total++; if (timed_out || len != 3 || n_rd != 3 || n_mreq != 3 || n_wr != 0) begin bad++; $display("FAIL alias_mread len/rd/mreq/wr got=%0d/%0d/%0d/%0d want=3/3/3/0", len, n_rd, n_mreq, n_wr); end
    endtask

    task automatic test_back_to_back();
        int n_done, n_acc_done, last_c;
        n_done = 0; n_acc_done = 0; n_mreq = 0; last_c = 0;
        start = 1'b1; cycle_type = 3'd1; addr_in = 16'h4000;
        #1;
        total++; if (accept !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", accept); end
        for (int c = 1; c <= 30; c++) begin
            tick();
            n_mreq += int'(mreq);
            if (done) begin
                n_done++;
                if (accept) n_acc_done++;
            end
            if (c == 7) start = 1'b0;
            if (n_done == 3) begin
                last_c = c;
                break;
            end
        end
        start = 1'b0;
        total++; if (last_c != 9 || n_mreq != 9) begin bad++; $display("FAIL b2b_len got=%0d clk %0d mreq want=9 clk 9 mreq", last_c, n_mreq); end
        total++; if (n_acc_done != 2) begin bad++; $display("FAIL b2b_done_accept got=%0d want=2", n_acc_done); end
        tick();
    endtask

    task automatic test_bus_grant();
        int n_done, n_busack, last_c;
        logic acc6, done6, busack7, pin_oe7, mreq7;
        n_done = 0; n_busack = 0; last_c = 0;
        acc6 = 1'bx; done6 = 1'bx; busack7 = 1'bx; pin_oe7 = 1'bx; mreq7 = 1'bx;
        start = 1'b1; cycle_type = 3'd1; addr_in = 16'h5000;
        #1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 6) begin acc6 = accept; done6 = done; end
            if (c == 7) begin busack7 = busack; pin_oe7 = pin_oe; mreq7 = mreq; end
            n_busack += int'(busack);
            if (done) n_done++;
            if (c == 4) busrq = 1'b1;
            if (c == 8) busrq = 1'b0;
            if (c == 12) start = 1'b0;
            if (n_done == 3) begin
                last_c = c;
                break;
            end
        end
        start = 1'b0; busrq = 1'b0;
        total++; if (done6 !== 1'b1 || acc6 !== 1'b0) begin bad++; $display("FAIL grant_blocks_accept done/accept got=%b/%b want=1/0", done6, acc6); end
        total++; if (busack7 !== 1'b1 || pin_oe7 !== 1'b0 || mreq7 !== 1'b0) begin bad++; $display("FAIL grant_pins busack/pin_oe/mreq got=%b/%b/%b want=1/0/0", busack7, pin_oe7, mreq7); end
        total++; if (n_busack != 4) begin bad++; $display("FAIL grant_len got=%0d want=4", n_busack); end
        total++; if (last_c != 14) begin bad++; $display("FAIL grant_resume got=%0d want=14", last_c); end
        tick();
        total++; if (pin_oe !== 1'b1 || busack !== 1'b0) begin bad++; $display("FAIL grant_release pin_oe/busack got=%b/%b want=1/0", pin_oe, busack); end
    endtask

    task automatic test_reset_mid_cycle();
        int n_done, n_iorq;
        n_done = 0; n_iorq = 0;
        start = 1'b1; cycle_type = 3'd3; addr_in = 16'h0077;
        #1;
        tick();
        start = 1'b0;
        tick();
        total++; if (iorq !== 1'b1 || rd !== 1'b1) begin bad++; $display("FAIL midrst_pre iorq/rd got=%b/%b want=1/1", iorq, rd); end
        #2 nreset = 1'b0;
        #1;
        total++; if ({iorq, rd, done, pin_oe, mreq} !== 5'b0 || addr_out !== 16'h0) begin bad++; $display("FAIL midrst_async got=%b addr=%h want=00000 addr=0000", {iorq, rd, done, pin_oe, mreq}, addr_out); end
        tick();
        tick();
        nreset = 1'b1;
        tick();
        total++; if (pin_oe !== 1'b1 || busack !== 1'b0) begin bad++; $display("FAIL midrst_release pin_oe/busack got=%b/%b want=1/0", pin_oe, busack); end
        for (int c = 0; c < 6; c++) begin
            n_done += int'(done);
            n_iorq += int'(iorq);
            tick();
        end
        total++; if (n_done != 0 || n_iorq != 0) begin bad++; $display("FAIL midrst_no_resume done/iorq got=%0d/%0d want=0/0", n_done, n_iorq); end
    endtask

    initial begin
        nreset = 1'b0; start = 1'b0; mwait = 1'b0; busrq = 1'b0;
        cycle_type = 3'd0; addr_in = '0; rfsh_addr = '0; db_in = '0;
        test_reset();
        test_fetch();
        test_mwrite_wait();
        test_io();
        test_inta();
        test_type_alias();
        test_back_to_back();
        test_bus_grant();
        test_reset_mid_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_cycle_sequencer.md
# bus_cycle_sequencer

Parametrised successor to the CPU pin-control logic. It runs a registered T-state machine that generates every external bus cycle type: opcode fetch, memory read/write, I/O read/write and interrupt acknowledge. Wait states are configurable per cycle class, `mwait` extends cycles, `busrq`/`busack` arbitration is synchronised, and back-to-back cycles run with no idle bubble. It sits between the instruction sequencer and the pin pads.

## Interface
- `AW`, 16, address width
- `DW`, 8, data width
- `MEM_WS`, 0, automatic wait states added to fetch/memory cycles
- `IO_WS`, 1, automatic wait states added to I/O cycles
- `INTA_WS`, 2, automatic wait states added to interrupt acknowledge (≥1)
- `BUSRQ_SYNC`, 2, synchroniser stages on `busrq` (≥1)

Ports:
- `clk`  in  1  clock; one clk period = one T-state
- `nreset`  in  1  reset, asynchronous, active-low
- `start`  in  1  cycle request, level; held until `accept`
- `cycle_type`  in  3  0 fetch, 1 mread, 2 mwrite, 3 ioread, 4 iowrite, 5 inta; 6–7 treated as mread
- `addr_in`  in  AW  cycle address, sampled at `accept`
- `rfsh_addr`  in  AW  refresh address, sampled at entry to T3 of fetch/inta
- `db_in`  in  DW  data pins
- `mwait`, `busrq`  in  1  active-high pin requests; `mwait` is synchronous to `clk`
- `accept`  out  1  combinational; request taken this cycle
- `done`  out  1  registered 1-cycle pulse in the final T-state
- `rdata`  out  DW  captured read data; stable until next capture
- `addr_out`  out  AW  registered address pad latch
- `m1`, `mreq`, `iorq`, `rd`, `wr`, `rfsh`, `busack`  out  1  registered, active-high strobes
- `pin_oe`  out  1  enable for address/control pads
- `db_oe`  out  1  data pad drive

## Operation
- States: IDLE, T1, T2, TW, T3, T4, GRANT. Auto-wait counter `wcnt` is loaded at T1 with the class count: MEM_WS (fetch/mread/mwrite), IO_WS, INTA_WS.
- `accept` = `start` & ~`busrq_s` & (IDLE | final T-state). The final T-state is T4 for fetch/inta and T3 otherwise. On accept: next state T1; latch `cycle_type`; `addr_out` ← `addr_in`.
- Final state without accept: go to GRANT if `busrq_s`, else IDLE. IDLE with `busrq_s` goes to GRANT. `busrq` is sampled only in IDLE or the final state.
- T1→T2. T2/TW: if `wcnt`≠0, go to TW and decrement. Else if `mwait`=1, go to TW and hold. Else go to T3. T3→T4 for fetch/inta only.
- GRANT: `busack`=1, `pin_oe`=0, `db_oe`=0, all strobes 0. Leave to IDLE when `busrq_s`=0.
- Strobes are active in these states:
  - fetch: `m1`, `mreq`, `rd` in T1/T2/TW; `mreq`, `rfsh` in T3/T4.
  - mread: `mreq`, `rd` in T1–T3.
  - mwrite: `mreq` in T1–T3; `wr` in T2/TW; `db_oe` in T1–T3.
  - ioread: `iorq`, `rd` in T2/TW/T3.
  - iowrite: `iorq`, `wr` in T2/TW/T3; `db_oe` in T1–T3.
  - inta: `m1` in T1/T2/TW; `iorq` in TW only; `mreq`, `rfsh` in T3/T4.
- Read data capture: `rdata` ← `db_in` at the edge leaving the last T2/TW for fetch/inta, and at the edge leaving T3 for mread/ioread.
- `addr_out` ← `rfsh_addr` on entry to T3 of fetch/inta.
- `pin_oe` = ~`busack`, registered.

## Timing
- All outputs except `accept` are registered from next-state. A state's strobes appear the cycle the machine is in that state.
- Reset (`nreset`=0, async): state IDLE, all outputs 0 including `pin_oe`, `addr_out`=0, `rdata`=0, synchroniser flops 0, `wcnt`=0. The first edge after release sets `pin_oe`=1.
- Reset mid-cycle: the cycle is aborted immediately. No `done`, and the request is not remembered.
- Cycle lengths with defaults and no `mwait`:
  - fetch: 4 clk
  - mread and mwrite: 3 clk
  - ioread and iowrite: 4 clk (T1 T2 TW T3)
  - inta: 6 clk (T1 T2 TW TW T3 T4)
- Each held `mwait` edge adds 1 clk.
- `mwait` is ignored while `wcnt`≠0. It is sampled only at edges leaving T2/TW.
- Back-to-back: accepting in the final state gives T1 on the next clk with no idle cycle. In that case `done` and the new `accept` coincide.
- `busack` rises 1 clk after the final state or IDLE where `busrq_s`=1. `busrq_s` lags `busrq` by BUSRQ_SYNC clk.
- `busack` falls 1 clk after `busrq_s`=0.
- `busrq` and `start` together in IDLE or the final state: the bus grant wins, and `start` stays pending.

## Test plan
- Reset then fetch of addr 0x1234, `rfsh_addr`=0x007F, `db_in`=0xA5 → `m1` and `rd` for 2 clk, `rfsh` for 2 clk, `addr_out` 0x1234→0x007F, `rdata`=0xA5, `done` in clk 4.
- mwrite at 0x8000 with `mwait` high for 2 sample edges → 5-clk cycle; `wr` high 3 clk; `db_oe` high for T1..T3.
- ioread, IO_WS=1, `db_in`=0x3C → `iorq`/`rd` high 3 clk, `rdata`=0x3C, total 4 clk. With IO_WS=3, total 6 clk.
- inta with INTA_WS=2 → `iorq` high only during the 2 TW clk, `m1` high 4 clk, `rfsh` high in T3/T4, total 6 clk.
- `start` held for 3 consecutive mreads → 9 clk, 3 `done` pulses, no IDLE between cycles. Raise `busrq` during the 2nd mread → grant after the 2nd `done`, `pin_oe`=0; drop `busrq` → 3rd mread resumes.
- Pull `nreset` low in T2 of an ioread → all strobes 0 asynchronously, no `done`; after release, state IDLE and `pin_oe`=1 after 1 clk.
